// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: operation codes, FSM state
// encodings and the multiply pass count.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_SUB16 = 2'b01,
        OP_MUL8  = 2'b10,
        OP_CMP16 = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int unsigned MUL_STEPS = 8;

endpackage

// File: rtl/Adder.sv
// 8-bit adder datapath with optional operand inversion.
// Ports:
//   x, y       in  8 : operand lanes
//   x_inv      in  1 : invert x before adding
//   y_inv      in  1 : invert y before adding
//   cin        in  1 : carry in
//   sum        out 8 : sum
//   cout       out 1 : carry out of bit 7
//   acout      out 1 : auxiliary (half) carry out of bit 3
module Adder (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       x_inv,
    input  logic       y_inv,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       acout
);

    logic [7:0] x_eff;
    logic [7:0] y_eff;
    logic [4:0] lo_nib;
    logic [4:0] hi_nib;

    assign x_eff  = x ^ {8{x_inv}};
    assign y_eff  = y ^ {8{y_inv}};

    // Split into nibbles so the carry out of bit 3 is visible.
    assign lo_nib = {1'b0, x_eff[3:0]} + {1'b0, y_eff[3:0]} + {4'd0, cin};
    assign hi_nib = {1'b0, x_eff[7:4]} + {1'b0, y_eff[7:4]} + {4'd0, lo_nib[4]};

    assign sum    = {hi_nib[3:0], lo_nib[3:0]};
    assign cout   = hi_nib[4];
    assign acout  = lo_nib[4];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller time-sharing one 8-bit Adder for 16-bit add,
// subtract, compare and an 8x8 unsigned shift-and-add multiply.
// Ports:
//   clk    in  1  : clock, rising edge
//   rst    in  1  : asynchronous active-high reset
//   start  in  1  : request, sampled only while ready
//   op     in  2  : 00 ADD16, 01 SUB16, 10 MUL8, 11 CMP16
//   a, b   in  16 : operands (MUL8 uses the low bytes)
//   ready  out 1  : high in IDLE only
//   done   out 1  : one-cycle pulse when result/flags update
//   result out 16 : last completed result
//   carry  out 1  : carry flag (1 = no borrow for subtract/compare)
//   half   out 1  : half-carry flag
//   zero   out 1  : zero flag
module alu_sequencer
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        half,
    output logic        zero
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_STEPS - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  lo_q, lo_d;
    logic        cint_q, cint_d;
    logic        hint_q, hint_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  mpl_q, mpl_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        half_q, half_d;
    logic        zero_q, zero_d;
    logic        done_q, done_d;

    logic [7:0]  add_x;
    logic [7:0]  add_y;
    logic        add_y_inv;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;
    logic        add_acout;

    logic        sub_mode;
    logic [15:0] hi_result;
    logic [8:0]  mul_wide;
    logic [7:0]  acc_next;
    logic [7:0]  mpl_next;

    Adder u_adder (
        .x     (add_x),
        .y     (add_y),
        .x_inv (1'b0),
        .y_inv (add_y_inv),
        .cin   (add_cin),
        .sum   (add_sum),
        .cout  (add_cout),
        .acout (add_acout)
    );

    // Subtract and compare both use two's complement: invert Y, carry in 1.
    assign sub_mode  = (op_q != OP_ADD16);
    assign hi_result = {add_sum, lo_q};

    // Multiplier LSB selects sum or plain accumulator, then
    // {carry, acc, multiplier} shifts right one bit.
    assign mul_wide  = mpl_q[0] ? {add_cout, add_sum} : {1'b0, acc_q};
    assign acc_next  = mul_wide[8:1];
    assign mpl_next  = {mul_wide[0], mpl_q[7:1]};

    // Adder lane muxes
    always_comb begin
        add_x     = 8'd0;
        add_y     = 8'd0;
        add_y_inv = 1'b0;
        add_cin   = 1'b0;
        unique case (state_q)
            LO: begin
                add_x     = a_q[7:0];
                add_y     = b_q[7:0];
                add_y_inv = sub_mode;
                add_cin   = sub_mode;
            end
            HI: begin
                add_x     = a_q[15:8];
                add_y     = b_q[15:8];
                add_y_inv = sub_mode;
                add_cin   = cint_q;
            end
            MUL: begin
                add_x     = acc_q;
                add_y     = b_q[7:0];
            end
            default: ;
        endcase
    end

    // Next-state and register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_d     = lo_q;
        cint_d   = cint_q;
        hint_d   = hint_q;
        acc_d    = acc_q;
        mpl_d    = mpl_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        half_d   = half_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    cint_d  = 1'b0;
                    acc_d   = 8'd0;
                    mpl_d   = a[7:0];
                    cnt_d   = 3'd0;
                    state_d = (op_e'(op) == OP_MUL8) ? MUL : LO;
                end
            end
            LO: begin
                lo_d    = add_sum;
                cint_d  = add_cout;
                hint_d  = add_acout;
                state_d = HI;
            end
            HI: begin
                // Compare updates the flags but leaves the result alone.
                if (op_q != OP_CMP16) begin
                    result_d = hi_result;
                end
                carry_d = add_cout;
                half_d  = hint_q;
                zero_d  = (hi_result == 16'd0);
                done_d  = 1'b1;
                state_d = DONE;
            end
            MUL: begin
                acc_d = acc_next;
                mpl_d = mpl_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == MUL_LAST) begin
                    result_d = {acc_next, mpl_next};
                    carry_d  = 1'b0;
                    half_d   = 1'b0;
                    zero_d   = ({acc_next, mpl_next} == 16'd0);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD16;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            lo_q     <= 8'd0;
            cint_q   <= 1'b0;
            hint_q   <= 1'b0;
            acc_q    <= 8'd0;
            mpl_q    <= 8'd0;
            cnt_q    <= 3'd0;
            result_q <= 16'd0;
            carry_q  <= 1'b0;
            half_q   <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            cint_q   <= cint_d;
            hint_q   <= hint_d;
            acc_q    <= acc_d;
            mpl_q    <= mpl_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            half_q   <= half_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign half   = half_q;
    assign zero   = zero_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that time-shares one 8-bit `Adder` instance to execute 16-bit add, subtract and compare, plus an 8×8 unsigned shift-and-add multiply. It sits between the microprocessor's control unit and the adder datapath. It sequences the adder's X/Y operand lanes and its X_inv/Y_inv/Cin controls byte by byte. It returns a 16-bit result and carry/half-carry/zero flags with a start/ready/done handshake.

## Interface
Parameters:
- none; operand width is fixed at 8 bits per pass.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when `ready`=1.
- `op` in 2: 00 ADD16, 01 SUB16, 10 MUL8, 11 CMP16.
- `a` in 16: operand A; MUL8 uses `a[7:0]` only.
- `b` in 16: operand B; MUL8 uses `b[7:0]` only.
- `ready` out 1: 1 in IDLE only.
- `done` out 1: one-cycle pulse when result and flags update.
- `result` out 16: last completed result.
- `carry` out 1: carry flag.
- `half` out 1: half-carry flag.
- `zero` out 1: zero flag.

## Operation
- States and transitions:
  - IDLE: `start`=1 latches `op`, `a` and `b`. Goes to LO for ADD16/SUB16/CMP16, to MUL for MUL8. `start`=0 stays in IDLE.
  - LO: adder gets `a[7:0]`, `b[7:0]`. Cin=0 and Y_inv=0 for ADD16. Cin=1 and Y_inv=1 for SUB16/CMP16. Register the low sum, Cout as the internal carry, and ACout. Go to HI.
  - HI: adder gets `a[15:8]`, `b[15:8]`, with Cin = internal carry and the same Y_inv as LO. Register the high sum and Cout. Go to DONE.
  - MUL: 3-bit iteration counter, 8 passes.
    - Each pass: adder X = accumulator high byte, Y = multiplicand, Cin=0.
    - If the multiplier LSB is 1, take the sum; otherwise keep the accumulator.
    - Then shift {carry-out, accumulator high byte, multiplier} right by one bit.
    - After the 8th pass, go to DONE.
  - DONE: `done`=1 for one cycle, flags/result update. Go to IDLE.
- Flag rules:
  - ADD16/SUB16: `carry` = HI-pass Cout. For SUB16, 1 means no borrow. `half` = LO-pass ACout. `zero` = (16-bit result == 0).
  - CMP16: same as SUB16, but the flags update and `result` holds its previous value.
  - MUL8: `carry`=0, `half`=0, `zero` = (product == 0).
- X_inv is tied 0. It is available to future ops and is unused here.
- `start` while `ready`=0 is ignored; no queueing.
- Operands are latched, so changes to `a`, `b` or `op` after acceptance have no effect.

## Timing
- Reset values: state IDLE; `ready`=1, `done`=0, `result`=0x0000, `carry`=0, `half`=0, `zero`=0; internal registers 0.
- Start accepted at edge T. Latency:
  - ADD16/SUB16/CMP16: LO in T+1, HI in T+2, `done` and updated outputs in T+3, `ready`=1 in T+4.
  - MUL8: MUL in T+1..T+8, `done` in T+9, `ready`=1 in T+10.
- Outputs are registered and hold until the next DONE.
- Back-to-back: `start` held high re-issues at the first IDLE cycle.
- Reset mid-operation:
  - State returns to IDLE immediately and all outputs take their reset values.
  - No `done` pulse for the aborted op.
- Wrap-around: 16-bit results truncate, and the carry flag captures the overflow.

## Structure
- Shared package `alu_pkg` holds:
  - op encodings OP_ADD16, OP_SUB16, OP_MUL8, OP_CMP16;
  - state encodings IDLE, LO, HI, MUL, DONE;
  - constant MUL_STEPS = 8.
- One sub-module: the existing `Adder`, instantiated once. The sequencer contains only the lane muxes, FSM, counter, accumulator/shift registers and flag logic.

## Test plan
- ADD16, a=0x00FF, b=0x0001 -> result 0x0100, carry 0, half 1, zero 0; `done` exactly at T+3.
- ADD16, a=0xFFFF, b=0x0001 -> result 0x0000, carry 1, half 1, zero 1.
- SUB16 pair:
  - a=0x1000, b=0x0001 -> 0x0FFF, carry 1, half 0.
  - a=0x0001, b=0x0002 -> 0xFFFF, carry 0, zero 0.
- CMP16, a=0x1234, b=0x1234, issued after a result of 0xFFFF -> result stays 0xFFFF, zero 1, carry 1, half 1.
- MUL8:
  - a=0x00FF, b=0x00FF -> 0xFE01, `done` at T+9, carry 0.
  - a=0x0000, b=0x0037 -> 0x0000, zero 1.
- Protocol:
  - `start` pulsed at T+3 of a MUL8 -> ignored, with a single `done` at T+9.
  - `rst` asserted at T+4 of a MUL8 -> `ready`=1 immediately, `result`=0, no `done` pulse.
